address_register_bank: RTL

Parametrised address register bank for the datapath: a configurable number of WIDTH-bit address registers with per-register load/arithmetic functions, PC auto-step, stack-pointer bound checking and two independent combinational read ports. It is the successor to the fixed three-register PC/AR/SP file. It sits between the ALU/memory-data bus (input I) and the memory address mux (OutC/OutD).

---
 rtl/address_register_bank.sv | 65 ++++++
 1 files changed

// File: rtl/address_register_bank.sv
// address_register_bank: PC/AR/SP plus general address registers with per-register functions,
// PC auto-step, sticky SP bound flags and two combinational read ports.
module address_register_bank #(
  parameter int WIDTH = 16,
  parameter int NREG = 4,
  parameter int SEL_W = 2,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter logic [WIDTH-1:0] SP_RESET = '1,
  parameter logic [WIDTH-1:0] SP_LIMIT = 16'h0100
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [NREG-1:0]  RegSel,
  input  logic [2:0]       FunSel,
  input  logic             PcStep,
  input  logic             FlagClr,
  input  logic [SEL_W-1:0] OutCSel,
  input  logic [SEL_W-1:0] OutDSel,
  output logic [WIDTH-1:0] OutC,
  output logic [WIDTH-1:0] OutD,
  output logic             SpOvf,
  output logic             SpUnf
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] nxt [NREG];
  logic [WIDTH-1:0] rd [2**SEL_W];
  logic ovf_evt, unf_evt;
  function automatic logic [WIDTH-1:0] apply(input logic [2:0] f, input logic [WIDTH-1:0] r, d);
    return f == 3'b001 ? d :
           f == 3'b010 ? r + ONE :
           f == 3'b011 ? r - ONE :
           f == 3'b100 ? '0 :
           f == 3'b101 ? r + d : r;
  endfunction
  assign ovf_evt = !RegSel[2] && FunSel == 3'b011 && regs[2] == SP_LIMIT;
  assign unf_evt = !RegSel[2] && FunSel == 3'b010 && regs[2] == SP_RESET;
  always_comb begin
    for (int k = 0; k < NREG; k++) nxt[k] = RegSel[k] ? regs[k] : apply(FunSel, regs[k], I);
    if (RegSel[0] && PcStep) nxt[0] = regs[0] + ONE;
    if (ovf_evt || unf_evt) nxt[2] = regs[2];
  end
  // A set event on the same edge as FlagClr wins, so the flag stays 1.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < NREG; k++) regs[k] <= k == 0 ? PC_RESET : k == 2 ? SP_RESET : '0;
      SpOvf <= 1'b0;
      SpUnf <= 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++) regs[k] <= nxt[k];
      SpOvf <= ovf_evt | (SpOvf & ~FlagClr);
      SpUnf <= unf_evt | (SpUnf & ~FlagClr);
    end
  end
  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_rd
    if (k < NREG) begin : g_in
      assign rd[k] = regs[k];
    end else begin : g_out
      assign rd[k] = '0;
    end
  end
  assign OutC = rd[OutCSel];
  assign OutD = rd[OutDSel];
endmodule
